demux_sel_sequencer: RTL and testbench

DEMUX_SEL_SEQUENCER -- requirements
Module: demux_sel_sequencer

---
 rtl/demux_sel_sequencer.sv | 83 ++++++++
 tb/tb_demux_sel_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer: serialises a 16-bit frame into (data, sel, strobe) beats for a 1x16 demux.
module demux_sel_sequencer #(
    parameter int MSB_FIRST  = 0,
    parameter int GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic        abort,
    output logic        data_out,
    output logic [3:0]  sel_out,
    output logic        strobe,
    output logic        frame_done,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, gap_q, gap_d, sel_q, sel_d;
    logic [15:0] cap_q, cap_d;
    logic        data_q, data_d, strobe_q, strobe_d, done_q, done_d, busy_q, busy_d;
    logic        last, accept;
    always_comb begin
        last       = state_q == SHIFT && cnt_q == 4'd15;
        word_ready = !rst && !abort && (state_q == IDLE || (last && GAP_CYCLES == 0));
        accept     = word_valid && word_ready;
        cap_d      = accept ? word_in : cap_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else if (accept) begin
            state_d = SHIFT;
            cnt_d   = 4'd0;
        end else if (last) begin
            state_d = GAP_CYCLES > 0 ? GAP : IDLE;
            cnt_d   = 4'd0;
            gap_d   = 4'(GAP_CYCLES - 1);
        end else if (state_q == SHIFT) begin
            cnt_d = cnt_q + 4'd1;
        end else if (state_q == GAP) begin
            state_d = gap_q == 4'd0 ? IDLE : GAP;
            gap_d   = gap_q - 4'd1;
        end
        // outputs are computed from the next state so they register alongside it
        strobe_d = state_d == SHIFT;
        sel_d    = !strobe_d ? 4'd0 : (MSB_FIRST != 0 ? 4'd15 - cnt_d : cnt_d);
        data_d   = strobe_d && cap_d[sel_d];
        done_d   = strobe_d && cnt_d == 4'd15;
        busy_d   = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            gap_q    <= 4'd0;
            cap_q    <= 16'd0;
            sel_q    <= 4'd0;
            data_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            cap_q    <= cap_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end
    assign data_out   = data_q;
    assign sel_out    = sel_q;
    assign strobe     = strobe_q;
    assign frame_done = done_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_demux_sel_sequencer.sv
// tb_demux_sel_sequencer: three parameterisations driven in lockstep, each checked every cycle
// against a model that tracks only "cycles since accept" and the captured word.
module tb_demux_sel_sequencer;
    logic        clk = 1'b0;
    logic        rst, word_valid, abort;
    logic [15:0] word_in;
    logic [2:0]  rdy, dout, stb, fd, bsy, acc;
    logic [3:0]  sel [3];
    int          errs = 0, checks = 0;
    int          pos [3];
    logic [15:0] w [3];
    always #5 clk = ~clk;
    demux_sel_sequencer #(.MSB_FIRST(0), .GAP_CYCLES(0)) u0 (.clk(clk), .rst(rst), .word_in(word_in),
        .word_valid(word_valid), .word_ready(rdy[0]), .abort(abort), .data_out(dout[0]),
        .sel_out(sel[0]), .strobe(stb[0]), .frame_done(fd[0]), .busy(bsy[0]));
    demux_sel_sequencer #(.MSB_FIRST(1), .GAP_CYCLES(0)) u1 (.clk(clk), .rst(rst), .word_in(word_in),
        .word_valid(word_valid), .word_ready(rdy[1]), .abort(abort), .data_out(dout[1]),
        .sel_out(sel[1]), .strobe(stb[1]), .frame_done(fd[1]), .busy(bsy[1]));
    demux_sel_sequencer #(.MSB_FIRST(0), .GAP_CYCLES(3)) u2 (.clk(clk), .rst(rst), .word_in(word_in),
        .word_valid(word_valid), .word_ready(rdy[2]), .abort(abort), .data_out(dout[2]),
        .sel_out(sel[2]), .strobe(stb[2]), .frame_done(fd[2]), .busy(bsy[2]));
    function automatic int msb_of(int i);
        return i == 1 ? 1 : 0;
    endfunction
    function automatic int gap_of(int i);
        return i == 2 ? 3 : 0;
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // one clock: compare at the falling edge, then advance the model on the rising edge
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            int         p;
            logic       s, er;
            logic [3:0] sl;
            p  = pos[i];
            s  = p >= 0 && p < 16;
            sl = !s ? 4'd0 : (msb_of(i) != 0 ? 4'(15 - p) : 4'(p));
            er = !rst && !abort && (p < 0 || (p == 15 && gap_of(i) == 0));
            chk($sformatf("u%0d ready t=%0t", i, $time), 32'(rdy[i]), 32'(er));
            chk($sformatf("u%0d strobe t=%0t", i, $time), 32'(stb[i]), 32'(s));
            chk($sformatf("u%0d sel t=%0t", i, $time), 32'(sel[i]), 32'(sl));
            chk($sformatf("u%0d data t=%0t", i, $time), 32'(dout[i]), 32'(s && w[i][sl]));
            chk($sformatf("u%0d done t=%0t", i, $time), 32'(fd[i]), 32'(p == 15));
            chk($sformatf("u%0d busy t=%0t", i, $time), 32'(bsy[i]), 32'(p >= 0));
            acc[i] = word_valid && er;
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst || abort) pos[i] = -1;
            else if (acc[i]) begin
                pos[i] = 0;
                w[i]   = word_in;
            end else if (pos[i] >= 0) begin
                pos[i]++;
                if (pos[i] >= 16 + gap_of(i)) pos[i] = -1;
            end
        end
        #1;
    endtask
    task automatic wait_pos0(input int target);
        int n = 0;
        while (pos[0] != target && n < 40) begin
            step();
            n++;
        end
        chk("wait_pos0", 32'(pos[0]), 32'(target));
    endtask
    initial begin
        int k, n;
        rst = 1'b1; abort = 1'b0; word_valid = 1'b0; word_in = 16'h0;
        for (int i = 0; i < 3; i++) begin
            pos[i] = -1;
            w[i]   = 16'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        word_valid = 1'b1; word_in = 16'hA5C3;
        step();
        word_valid = 1'b0;
        repeat (24) step();
        word_valid = 1'b1; word_in = 16'h8001;
        step();
        word_valid = 1'b0;
        repeat (24) step();
        // hold valid: u0/u1 run back-to-back, u2 takes its second word after the gap
        word_valid = 1'b1; word_in = 16'hFFFF; k = 0; n = 0;
        while (k < 2 && n < 80) begin
            step();
            if (acc[2]) begin
                k++;
                word_in = 16'h0000;
            end
            n++;
        end
        chk("u2 accepts", 32'(k), 32'd2);
        word_valid = 1'b0;
        repeat (40) step();
        word_valid = 1'b1; word_in = 16'h3C5A;
        step();
        word_valid = 1'b0;
        wait_pos0(7);
        abort = 1'b1; word_valid = 1'b1; word_in = 16'hFFFF;
        step();
        abort = 1'b0; word_valid = 1'b0;
        repeat (3) step();
        word_valid = 1'b1; word_in = 16'h1234;
        step();
        word_valid = 1'b0;
        wait_pos0(10);
        rst = 1'b1;
        step();
        rst = 1'b0; word_valid = 1'b1; word_in = 16'hBEEF;
        step();
        word_valid = 1'b0;
        repeat (24) step();
        for (int c = 0; c < 800; c++) begin
            rst        = $urandom % 64 == 0;
            abort      = $urandom % 24 == 0;
            word_valid = $urandom % 3 != 0;
            word_in    = 16'($urandom);
            step();
        end
        rst = 1'b0; abort = 1'b0; word_valid = 1'b0;
        repeat (24) step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
